// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Opcodes, funct codes, FSM states and ALU helper shared by
//               the multi-cycle MIPS-subset core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [5:0] c_OP_RTYPE = 6'd0;
  localparam logic [5:0] c_OP_J     = 6'd2;
  localparam logic [5:0] c_OP_BEQ   = 6'd4;
  localparam logic [5:0] c_OP_BNE   = 6'd5;
  localparam logic [5:0] c_OP_ADDI  = 6'd8;
  localparam logic [5:0] c_OP_SLTI  = 6'd10;
  localparam logic [5:0] c_OP_LW    = 6'd35;
  localparam logic [5:0] c_OP_SW    = 6'd43;

  localparam logic [5:0] c_FN_ADD = 6'd32;
  localparam logic [5:0] c_FN_SUB = 6'd34;
  localparam logic [5:0] c_FN_AND = 6'd36;
  localparam logic [5:0] c_FN_OR  = 6'd37;
  localparam logic [5:0] c_FN_SLT = 6'd42;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_sel_t;

  function automatic logic [31:0] f_alu(input alu_op_t i_op, input logic [31:0] i_a,
                                        input logic [31:0] i_b);
    logic [31:0] y;
    case (i_op)
      ALU_AND: y = i_a & i_b;
      ALU_OR:  y = i_a | i_b;
      ALU_ADD: y = i_a + i_b;
      ALU_SUB: y = i_a - i_b;
      ALU_SLT: y = {31'd0, $signed(i_a) < $signed(i_b)};
      default: y = '0;
    endcase
    return y;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Next-state and datapath control decode for the multi-cycle core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import cpu_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  input  logic       i_aligned,
  input  logic       i_mem_ack,
  output state_t     o_next_state,
  output logic       o_ir_we,
  output logic       o_ab_we,
  output logic       o_alu_out_we,
  output logic       o_alu_src_imm,
  output alu_op_t    o_alu_op,
  output logic       o_pc_we,
  output pc_sel_t    o_pc_sel,
  output logic       o_mdr_we,
  output logic       o_rf_we,
  output logic       o_rf_dst_rd,
  output logic       o_rf_src_mem,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_retire,
  output logic       o_halt
);

  logic    w_legal;
  logic    w_funct_ok;
  alu_op_t w_funct_op;

  always_comb begin
    w_funct_ok = 1'b1;
    w_funct_op = ALU_ADD;
    w_legal    = 1'b0;
    case (i_funct)
      c_FN_ADD: w_funct_op = ALU_ADD;
      c_FN_SUB: w_funct_op = ALU_SUB;
      c_FN_AND: w_funct_op = ALU_AND;
      c_FN_OR:  w_funct_op = ALU_OR;
      c_FN_SLT: w_funct_op = ALU_SLT;
      default:  w_funct_ok = 1'b0;
    endcase
    case (i_opcode)
      c_OP_RTYPE: w_legal = w_funct_ok;
      c_OP_J, c_OP_BEQ, c_OP_BNE, c_OP_ADDI,
      c_OP_SLTI, c_OP_LW, c_OP_SW: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    o_next_state  = i_state;
    o_ir_we       = 1'b0;
    o_ab_we       = 1'b0;
    o_alu_out_we  = 1'b0;
    o_alu_src_imm = 1'b0;
    o_alu_op      = ALU_ADD;
    o_pc_we       = 1'b0;
    o_pc_sel      = PC_SEQ;
    o_mdr_we      = 1'b0;
    o_rf_we       = 1'b0;
    o_rf_dst_rd   = 1'b0;
    o_rf_src_mem  = 1'b0;
    o_mem_req     = 1'b0;
    o_mem_we      = 1'b0;
    o_retire      = 1'b0;
    o_halt        = 1'b0;
    case (i_state)
      S_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          o_ir_we      = 1'b1;
          o_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        o_ab_we = 1'b1;
        if (i_opcode == c_OP_J) begin
          o_pc_we      = 1'b1;
          o_pc_sel     = PC_JUMP;
          o_retire     = 1'b1;
          o_next_state = S_FETCH;
        end else if (!w_legal) begin
          o_next_state = S_HALT;
        end else begin
          o_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        o_alu_out_we = 1'b1;
        case (i_opcode)
          c_OP_RTYPE: begin
            o_alu_op     = w_funct_op;
            o_next_state = S_WB;
          end
          c_OP_ADDI, c_OP_SLTI: begin
            o_alu_src_imm = 1'b1;
            o_alu_op      = (i_opcode == c_OP_SLTI) ? ALU_SLT : ALU_ADD;
            o_next_state  = S_WB;
          end
          c_OP_BEQ, c_OP_BNE: begin
            o_alu_op     = ALU_SUB;
            o_pc_we      = 1'b1;
            o_pc_sel     = ((i_opcode == c_OP_BEQ) == i_zero) ? PC_BRANCH : PC_SEQ;
            o_retire     = 1'b1;
            o_next_state = S_FETCH;
          end
          default: begin
            // Only lw/sw reach here; a misaligned address faults before any request.
            o_alu_src_imm = 1'b1;
            o_next_state  = i_aligned ? S_MEM : S_HALT;
          end
        endcase
      end
      S_MEM: begin
        o_mem_req = 1'b1;
        o_mem_we  = (i_opcode == c_OP_SW);
        if (i_mem_ack) begin
          if (i_opcode == c_OP_SW) begin
            o_pc_we      = 1'b1;
            o_retire     = 1'b1;
            o_next_state = S_FETCH;
          end else begin
            o_mdr_we     = 1'b1;
            o_next_state = S_WB;
          end
        end
      end
      S_WB: begin
        o_rf_we      = 1'b1;
        o_rf_dst_rd  = (i_opcode == c_OP_RTYPE);
        o_rf_src_mem = (i_opcode == c_OP_LW);
        o_pc_we      = 1'b1;
        o_retire     = 1'b1;
        o_next_state = S_FETCH;
      end
      S_HALT: o_halt = 1'b1;
      default: o_next_state = S_HALT;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_cpu.sv
// ============================================================================
// Module      : multicycle_cpu
// Description : Multi-cycle MIPS-subset core with a shared req/ack memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              retire_o,
  output logic              halt_o
);

  state_t            r_state, w_next_state;
  logic [ADDR_W-1:0] r_pc, r_pc4, w_pc_next, w_br_target, w_j_target;
  logic [31:0]       r_ir, r_a, r_b, r_alu_out, r_mdr;
  logic [31:0]       r_rf [0:31];
  logic [31:0]       w_simm, w_imm_sh, w_j_full, w_alu_b, w_alu_y, w_rf_wdata;
  logic [4:0]        w_rf_dst;
  logic [1:0]        w_addr_lo;

  logic    w_ir_we, w_ab_we, w_alu_out_we, w_alu_src_imm, w_pc_we, w_mdr_we;
  logic    w_rf_we, w_rf_dst_rd, w_rf_src_mem, w_mem_req, w_mem_we, w_retire, w_halt;
  alu_op_t w_alu_op;
  pc_sel_t w_pc_sel;

  multicycle_ctrl u_ctrl (
    .i_state       (r_state),
    .i_opcode      (r_ir[31:26]),
    .i_funct       (r_ir[5:0]),
    .i_zero        (r_a == r_b),
    .i_aligned     (w_addr_lo == 2'b00),
    .i_mem_ack     (mem_ack_i),
    .o_next_state  (w_next_state),
    .o_ir_we       (w_ir_we),
    .o_ab_we       (w_ab_we),
    .o_alu_out_we  (w_alu_out_we),
    .o_alu_src_imm (w_alu_src_imm),
    .o_alu_op      (w_alu_op),
    .o_pc_we       (w_pc_we),
    .o_pc_sel      (w_pc_sel),
    .o_mdr_we      (w_mdr_we),
    .o_rf_we       (w_rf_we),
    .o_rf_dst_rd   (w_rf_dst_rd),
    .o_rf_src_mem  (w_rf_src_mem),
    .o_mem_req     (w_mem_req),
    .o_mem_we      (w_mem_we),
    .o_retire      (w_retire),
    .o_halt        (w_halt)
  );

  assign w_simm      = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_imm_sh    = {w_simm[29:0], 2'b00};
  assign w_br_target = r_pc4 + w_imm_sh[ADDR_W-1:0];
  assign w_j_full    = {4'(r_pc4 >> 28), r_ir[25:0], 2'b00};
  assign w_j_target  = w_j_full[ADDR_W-1:0];
  assign w_addr_lo   = r_a[1:0] + w_simm[1:0];
  assign w_alu_b     = w_alu_src_imm ? w_simm : r_b;
  assign w_alu_y     = f_alu(w_alu_op, r_a, w_alu_b);
  assign w_rf_dst    = w_rf_dst_rd ? r_ir[15:11] : r_ir[20:16];
  assign w_rf_wdata  = w_rf_src_mem ? r_mdr : r_alu_out;

  always_comb begin
    case (w_pc_sel)
      PC_BRANCH: w_pc_next = w_br_target;
      PC_JUMP:   w_pc_next = w_j_target;
      default:   w_pc_next = r_pc4;
    endcase
  end

  // Reset gates the port combinationally so an in-flight request drops at once.
  assign mem_req_o   = rst_i & w_mem_req;
  assign mem_we_o    = mem_req_o & w_mem_we;
  assign mem_addr_o  = !mem_req_o ? '0 : ((r_state == S_FETCH) ? r_pc : r_alu_out[ADDR_W-1:0]);
  assign mem_wdata_o = mem_we_o ? r_b : '0;
  assign pc_o        = r_pc;
  assign retire_o    = w_retire;
  assign halt_o      = w_halt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_pc4     <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_ir_we) begin
        r_ir  <= mem_rdata_i;
        r_pc4 <= r_pc + ADDR_W'(32'd4);
      end
      if (w_ab_we) begin
        r_a <= r_rf[r_ir[25:21]];
        r_b <= r_rf[r_ir[20:16]];
      end
      if (w_alu_out_we) r_alu_out <= w_alu_y;
      if (w_mdr_we)     r_mdr     <= mem_rdata_i;
      if (w_pc_we)      r_pc      <= w_pc_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (w_rf_we && (w_rf_dst != 5'd0)) begin
      r_rf[w_rf_dst] <= w_rf_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_cpu.sv
// ============================================================================
// Module      : tb_multicycle_cpu
// Description : Directed self-checking bench for multicycle_cpu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_cpu;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Default-parameter core with a word memory and programmable wait states.
  logic        rst_i;
  logic        a_req, a_we, a_ack, a_retire, a_halt;
  logic [31:0] a_addr, a_wdata, a_rdata, a_pc;
  logic [31:0] r_mem [0:127];
  int          a_wait = 0;
  int          a_cnt  = 0;

  multicycle_cpu u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mem_req_o   (a_req),
    .mem_we_o    (a_we),
    .mem_addr_o  (a_addr),
    .mem_wdata_o (a_wdata),
    .mem_rdata_i (a_rdata),
    .mem_ack_i   (a_ack),
    .pc_o        (a_pc),
    .retire_o    (a_retire),
    .halt_o      (a_halt)
  );

  assign a_ack   = a_req && (a_cnt == a_wait);
  assign a_rdata = r_mem[a_addr[8:2]];

  always @(posedge clk_i) begin
    if (!a_req || a_ack) a_cnt <= 0;
    else                 a_cnt <= a_cnt + 1;
    if (a_req && a_we && a_ack) r_mem[a_addr[8:2]] <= a_wdata;
  end

  // 16-bit core booting at 0x200 with a fixed ROM and gateable ack.
  logic        b_rst = 1'b0;
  logic        b_ack_en = 1'b0;
  logic        b_req, b_we, b_ack, b_retire, b_halt;
  logic [15:0] b_addr, b_pc;
  logic [31:0] b_wdata, b_rdata;

  multicycle_cpu #(.ADDR_W(16), .RESET_PC(16'h0200)) u_dut16 (
    .clk_i       (clk_i),
    .rst_i       (b_rst),
    .mem_req_o   (b_req),
    .mem_we_o    (b_we),
    .mem_addr_o  (b_addr),
    .mem_wdata_o (b_wdata),
    .mem_rdata_i (b_rdata),
    .mem_ack_i   (b_ack),
    .pc_o        (b_pc),
    .retire_o    (b_retire),
    .halt_o      (b_halt)
  );

  assign b_ack = b_req && b_ack_en;
  always_comb begin
    case (b_addr)
      16'h0200: b_rdata = 32'h08003FFF;  // j -> 0xFFFC
      16'hFFFC: b_rdata = 32'h20010001;  // addi r1,r0,1
      16'h0000: b_rdata = 32'h1000FFFF;  // beq r0,r0,-1
      default:  b_rdata = 32'h0;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction
  function automatic logic [31:0] f_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] f_j(input int tgt);
    return {6'd2, 26'(tgt)};
  endfunction

  logic [31:0] acc_addr[$], acc_wdata[$], ret_pc[$];
  logic        acc_we[$];
  int          acc_cyc[$], ret_cyc[$];
  int          unstable, halt_first, halt_cycles;

  // Caller sits 1 time unit after the falling edge that begins cycle 1.
  task automatic run_dut(input bit sel_b, input int ncyc);
    logic        req, ack, we, ret, hlt, prev_req, prev_ack, cur_we;
    logic [31:0] addr, wdata, pc, cur_addr, cur_wdata;
    acc_addr.delete(); acc_wdata.delete(); acc_we.delete(); acc_cyc.delete();
    ret_pc.delete(); ret_cyc.delete();
    unstable = 0; halt_first = 0; halt_cycles = 0;
    prev_req = 1'b0; prev_ack = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_wdata = '0;
    for (int c = 1; c <= ncyc; c++) begin
      if (sel_b) begin
        req = b_req; ack = b_ack; we = b_we; ret = b_retire; hlt = b_halt;
        addr = {16'd0, b_addr}; wdata = b_wdata; pc = {16'd0, b_pc};
      end else begin
        req = a_req; ack = a_ack; we = a_we; ret = a_retire; hlt = a_halt;
        addr = a_addr; wdata = a_wdata; pc = a_pc;
      end
      if (req) begin
        if (!prev_req || prev_ack) begin
          acc_addr.push_back(addr); acc_we.push_back(we);
          acc_wdata.push_back(wdata); acc_cyc.push_back(c);
          cur_addr = addr; cur_we = we; cur_wdata = wdata;
        end else if (addr !== cur_addr || we !== cur_we || wdata !== cur_wdata) begin
          unstable++;
        end
      end
      if (ret) begin
        ret_pc.push_back(pc);
        ret_cyc.push_back(c);
      end
      if (hlt) begin
        halt_cycles++;
        if (halt_first == 0) halt_first = c;
      end
      prev_req = req;
      prev_ack = ack;
      @(negedge clk_i); #1;
    end
  endtask

  task automatic hold_reset_a();
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    for (int i = 0; i < 128; i++) r_mem[i] <= '0;
  endtask

  task automatic release_a(input int ws);
    a_wait = ws;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] exp_fa [7];
    int          exp_fc [7];

    // Reset values
    hold_reset_a();
    chk("rst_req", a_req, 0);
    chk("rst_we", a_we, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_wdata", a_wdata, 0);
    chk("rst_retire", a_retire, 0);
    chk("rst_halt", a_halt, 0);
    chk("rst_pc", a_pc, 0);

    // Zero-wait addi/addi/add
    r_mem[0] <= f_i(8, 0, 1, 5);
    r_mem[1] <= f_i(8, 0, 2, -3);
    r_mem[2] <= f_r(1, 2, 3, 32);
    r_mem[3] <= f_i(4, 0, 0, -1);
    release_a(0);
    run_dut(0, 12);
    chk("zw_retires", ret_pc.size(), 3);
    chk("zw_pc0", ret_pc[0], 32'h0);
    chk("zw_pc1", ret_pc[1], 32'h4);
    chk("zw_pc2", ret_pc[2], 32'h8);
    chk("zw_cyc2", ret_cyc[2], 12);
    chk("zw_r1", u_dut.r_rf[1], 32'd5);
    chk("zw_r2", u_dut.r_rf[2], 32'hFFFFFFFD);
    chk("zw_r3", u_dut.r_rf[3], 32'd2);

    // Three wait states on every access, lw
    hold_reset_a();
    r_mem[0]  <= f_i(35, 0, 4, 'h40);
    r_mem[16] <= 32'hDEADBEEF;
    release_a(3);
    run_dut(0, 11);
    chk("ws_retires", ret_pc.size(), 1);
    chk("ws_lw_cycles", ret_cyc[0], 11);
    chk("ws_accesses", acc_addr.size(), 2);
    chk("ws_ld_addr", acc_addr[1], 32'h40);
    chk("ws_ld_we", acc_we[1], 0);
    chk("ws_ld_start", acc_cyc[1], 7);
    chk("ws_stable", unstable, 0);
    chk("ws_r4", u_dut.r_rf[4], 32'hDEADBEEF);

    // Branches and jumps
    hold_reset_a();
    r_mem[0]  <= f_i(8, 0, 1, 1);
    r_mem[1]  <= f_j('h4);
    r_mem[4]  <= f_i(4, 1, 1, 2);
    r_mem[7]  <= f_i(5, 1, 1, 2);
    r_mem[8]  <= f_i(5, 1, 0, 2);
    r_mem[11] <= f_j('h40);
    r_mem[64] <= f_i(4, 0, 0, -1);
    release_a(0);
    run_dut(0, 20);
    exp_fa = '{32'h0, 32'h4, 32'h10, 32'h1C, 32'h20, 32'h2C, 32'h100};
    exp_fc = '{1, 5, 7, 10, 13, 16, 18};
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("br_fetch_addr%0d", i), acc_addr[i], exp_fa[i]);
      chk($sformatf("br_fetch_cyc%0d", i), acc_cyc[i], exp_fc[i]);
    end

    // ALU patterns: sub/and/or/slt/slti with negative operands
    hold_reset_a();
    r_mem[0] <= f_i(8, 0, 1, -7);
    r_mem[1] <= f_i(8, 0, 2, 12);
    r_mem[2] <= f_r(1, 2, 3, 34);
    r_mem[3] <= f_r(1, 2, 4, 36);
    r_mem[4] <= f_r(1, 2, 5, 37);
    r_mem[5] <= f_r(1, 2, 6, 42);
    r_mem[6] <= f_i(10, 2, 7, -1);
    r_mem[7] <= f_i(10, 1, 8, -1);
    r_mem[8] <= f_i(4, 0, 0, -1);
    release_a(0);
    run_dut(0, 33);
    chk("alu_sub", u_dut.r_rf[3], 32'hFFFFFFED);
    chk("alu_and", u_dut.r_rf[4], 32'h00000008);
    chk("alu_or", u_dut.r_rf[5], 32'hFFFFFFFD);
    chk("alu_slt", u_dut.r_rf[6], 32'd1);
    chk("alu_slti0", u_dut.r_rf[7], 32'd0);
    chk("alu_slti1", u_dut.r_rf[8], 32'd1);

    // Store/load round trip and r0 write
    hold_reset_a();
    r_mem[0] <= f_i(8, 0, 1, 5);
    r_mem[1] <= f_i(8, 0, 2, -3);
    r_mem[2] <= f_r(1, 2, 3, 32);
    r_mem[3] <= f_i(43, 0, 3, 8);
    r_mem[4] <= f_i(35, 0, 5, 8);
    r_mem[5] <= f_i(8, 0, 0, 7);
    r_mem[6] <= f_i(4, 0, 0, -1);
    release_a(0);
    run_dut(0, 28);
    chk("sl_st_addr", acc_addr[4], 32'h8);
    chk("sl_st_we", acc_we[4], 1);
    chk("sl_st_wdata", acc_wdata[4], 32'd2);
    chk("sl_st_cyc", acc_cyc[4], 16);
    chk("sl_ld_addr", acc_addr[6], 32'h8);
    chk("sl_ld_we", acc_we[6], 0);
    chk("sl_mem", r_mem[2], 32'd2);
    chk("sl_r5", u_dut.r_rf[5], 32'd2);
    chk("sl_r0", u_dut.r_rf[0], 32'd0);
    chk("sl_pc5", ret_pc[5], 32'h14);

    // Misaligned lw faults without a data request
    hold_reset_a();
    r_mem[0] <= f_i(35, 0, 1, 6);
    release_a(0);
    run_dut(0, 110);
    chk("mis_accesses", acc_addr.size(), 1);
    chk("mis_halt_first", halt_first, 4);
    chk("mis_halt_held", halt_cycles, 107);
    chk("mis_retires", ret_pc.size(), 0);
    chk("mis_pc", a_pc, 32'h0);
    hold_reset_a();
    chk("mis_rst_halt", a_halt, 0);

    // Illegal opcode 0x3F
    r_mem[0] <= {6'h3F, 26'd0};
    release_a(0);
    run_dut(0, 110);
    chk("ill_accesses", acc_addr.size(), 1);
    chk("ill_halt_first", halt_first, 3);
    chk("ill_halt_held", halt_cycles, 108);
    hold_reset_a();
    chk("ill_rst_halt", a_halt, 0);

    // 16-bit core: reset during a stalled fetch, then wrap at 0xFFFC
    @(negedge clk_i);
    b_rst = 1'b1;
    #1;
    repeat (3) begin
      @(negedge clk_i); #1;
    end
    chk("b_wait_req", b_req, 1);
    chk("b_wait_addr", b_addr, 32'h200);
    #2 b_rst = 1'b0;
    #1;
    chk("b_rst_req_drop", b_req, 0);
    chk("b_rst_pc", b_pc, 32'h200);
    @(negedge clk_i);
    b_ack_en = 1'b1;
    b_rst    = 1'b1;
    #1;
    run_dut(1, 10);
    chk("b_fetch0", acc_addr[0], 32'h0200);
    chk("b_fetch1", acc_addr[1], 32'hFFFC);
    chk("b_fetch2", acc_addr[2], 32'h0000);
    chk("b_fetch2_cyc", acc_cyc[2], 7);
    chk("b_ret_pc1", ret_pc[1], 32'hFFFC);
    chk("b_r1", u_dut16.r_rf[1], 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
